// File: rtl/lap_pkg.sv
// Shared types and constants for the stopwatch lap recall path.
// Build option: LAP_RECALL_BLINK_EN adds the disp_blank flashing output.
package lap_pkg;

  localparam int DIGITS             = 4;
  localparam int HOLD_TICKS_DEFAULT = 5;

  typedef logic [4*DIGITS-1:0] bcd_time_t;

  typedef logic [0:0] recall_state_t;
  localparam recall_state_t LIVE = 1'b0;
  localparam recall_state_t SHOW = 1'b1;

endpackage

// File: rtl/lap_ram.sv
// Lap time storage: synchronous write, asynchronous read, no reset on contents.
module lap_ram
  import lap_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  bcd_time_t       wdata,
  input  logic [AW-1:0]   raddr,
  output bcd_time_t       rdata
);

  bcd_time_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_recall.sv
// Lap recall controller: circular lap buffer plus newest-first playback to the display.
// Build option: LAP_RECALL_BLINK_EN adds disp_blank, toggled on each tick while a lap is shown.
module lap_recall
  import lap_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lap,
  input  logic                       clr,
  input  logic                       recall,
  input  logic                       tick,
  input  logic [4*DIGITS-1:0]        live_time,
  output logic [4*DIGITS-1:0]        disp_time,
  output logic                       recall_active,
  output logic [$clog2(DEPTH)-1:0]   lap_idx,
`ifdef LAP_RECALL_BLINK_EN
  output logic                       disp_blank,
`endif
  output logic [$clog2(DEPTH+1)-1:0] lap_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = $clog2(HOLD_TICKS+1);

  recall_state_t state, nxt_state;
  logic [AW-1:0] wr_ptr, nxt_wr;
  logic [CW-1:0] nxt_count;
  logic [AW-1:0] rd_age, nxt_age;
  logic [HW-1:0] hold, nxt_hold;
  logic          we;
  logic [AW-1:0] raddr;
  bcd_time_t     rdata;

  lap_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (live_time),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Event priority is clr > lap > recall > tick; any capture drops back to live view.
  always_comb begin
    nxt_state = state;
    nxt_wr    = wr_ptr;
    nxt_count = lap_count;
    nxt_age   = rd_age;
    nxt_hold  = hold;
    we        = 1'b0;
    if (clr) begin
      nxt_state = LIVE;
      nxt_wr    = '0;
      nxt_count = '0;
      nxt_age   = '0;
      nxt_hold  = '0;
    end else if (lap) begin
      we        = 1'b1;
      nxt_wr    = wr_ptr + AW'(1);
      if (lap_count != CW'(DEPTH)) begin
        nxt_count = lap_count + CW'(1);
      end
      nxt_state = LIVE;
      nxt_age   = '0;
      nxt_hold  = '0;
    end else if (recall) begin
      if (state == LIVE) begin
        if (lap_count != '0) begin
          nxt_state = SHOW;
          nxt_age   = '0;
          nxt_hold  = '0;
        end
      end else if ((CW'(rd_age) + CW'(1)) < lap_count) begin
        nxt_age  = rd_age + AW'(1);
        nxt_hold = '0;
      end else begin
        nxt_state = LIVE;
        nxt_age   = '0;
        nxt_hold  = '0;
      end
    end else if (tick && (state == SHOW)) begin
      if (hold == HW'(HOLD_TICKS-1)) begin
        nxt_state = LIVE;
        nxt_age   = '0;
        nxt_hold  = '0;
      end else begin
        nxt_hold = hold + HW'(1);
      end
    end
  end

  // Address the entry that will be on screen next cycle so disp_time moves with the state.
  assign raddr = wr_ptr - AW'(1) - nxt_age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LIVE;
      wr_ptr    <= '0;
      lap_count <= '0;
      rd_age    <= '0;
      hold      <= '0;
      disp_time <= '0;
    end else begin
      state     <= nxt_state;
      wr_ptr    <= nxt_wr;
      lap_count <= nxt_count;
      rd_age    <= nxt_age;
      hold      <= nxt_hold;
      disp_time <= (nxt_state == SHOW) ? rdata : live_time;
    end
  end

  assign recall_active = (state == SHOW);
  assign lap_idx       = rd_age;

`ifdef LAP_RECALL_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_blank <= 1'b0;
    end else if ((state == SHOW) && (nxt_state == SHOW)) begin
      disp_blank <= disp_blank ^ tick;
    end else begin
      disp_blank <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lap_recall.sv
// Self-checking bench for lap_recall: directed scenarios plus randomized traffic against a queue model.
module tb_lap_recall;
  import lap_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lap = 1'b0, clr = 1'b0, recall = 1'b0, tick = 1'b0;
  logic [15:0] live_time = 16'h0000;
  logic [15:0] disp_time;
  logic        recall_active;
  logic [1:0]  lap_idx;
  logic [2:0]  lap_count;
`ifdef LAP_RECALL_BLINK_EN
  logic        disp_blank;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: stored laps oldest-first, plus view state.
  logic [15:0] m_laps[$];
  bit          m_show;
  int          m_age;
  int          m_hold;
  bit          m_blank;
  logic [15:0] m_live;

  lap_recall #(.DEPTH(DEPTH), .HOLD_TICKS(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .lap           (lap),
    .clr           (clr),
    .recall        (recall),
    .tick          (tick),
    .live_time     (live_time),
    .disp_time     (disp_time),
    .recall_active (recall_active),
    .lap_idx       (lap_idx),
`ifdef LAP_RECALL_BLINK_EN
    .disp_blank    (disp_blank),
`endif
    .lap_count     (lap_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_laps.delete();
    m_show  = 0;
    m_age   = 0;
    m_hold  = 0;
    m_blank = 0;
    m_live  = 16'h0000;
  endtask

  task automatic model_update(input bit l, c, r, t, input logic [15:0] lt);
    bit was_show;
    was_show = m_show;
    if (c) begin
      m_laps.delete();
      m_show = 0; m_age = 0; m_hold = 0;
    end else if (l) begin
      m_laps.push_back(lt);
      if (m_laps.size() > DEPTH) void'(m_laps.pop_front());
      m_show = 0; m_age = 0; m_hold = 0;
    end else if (r) begin
      if (!m_show) begin
        if (m_laps.size() > 0) begin m_show = 1; m_age = 0; m_hold = 0; end
      end else if (m_age < m_laps.size() - 1) begin
        m_age++; m_hold = 0;
      end else begin
        m_show = 0; m_age = 0; m_hold = 0;
      end
    end else if (t && m_show) begin
      if (m_hold == HOLD - 1) begin m_show = 0; m_age = 0; m_hold = 0; end
      else m_hold++;
    end
    if (was_show && m_show) m_blank = m_blank ^ t;
    else m_blank = 0;
    m_live = lt;
  endtask

  function automatic logic [15:0] model_disp();
    if (m_show) return m_laps[m_laps.size() - 1 - m_age];
    return m_live;
  endfunction

  task automatic step(input bit l, c, r, t, input logic [15:0] lt);
    @(negedge clk);
    lap = l; clr = c; recall = r; tick = t; live_time = lt;
    @(posedge clk);
    model_update(l, c, r, t, lt);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (disp_time !== 16'h0000 || recall_active !== 1'b0 || lap_idx !== 2'd0 || lap_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got disp=%h act=%b idx=%0d cnt=%0d expected all zero",
               disp_time, recall_active, lap_idx, lap_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_live_idle();
    step(0, 0, 0, 0, 16'h0123);
    checks++;
    if (disp_time !== 16'h0123) begin
      errors++; $display("[TB] FAIL live_latency: got %h expected 0123", disp_time);
    end
    checks++;
    if (recall_active !== 1'b0 || lap_count !== 3'd0) begin
      errors++; $display("[TB] FAIL live_idle_state: got act=%b cnt=%0d expected 0/0", recall_active, lap_count);
    end
    step(0, 0, 1, 0, 16'h0124);
    checks++;
    if (recall_active !== 1'b0 || disp_time !== 16'h0124) begin
      errors++; $display("[TB] FAIL empty_recall: got act=%b disp=%h expected 0/0124", recall_active, disp_time);
    end
  endtask

  task automatic test_recall_seq();
    logic [15:0] exp_disp [3];
    exp_disp[0] = 16'h0056; exp_disp[1] = 16'h0034; exp_disp[2] = 16'h0012;
    step(1, 0, 0, 0, 16'h0012);
    step(1, 0, 0, 0, 16'h0034);
    step(1, 0, 0, 0, 16'h0056);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 16'h0999);
      checks++;
      if (disp_time !== exp_disp[i] || lap_idx !== 2'(i) || recall_active !== 1'b1) begin
        errors++;
        $display("[TB] FAIL recall_step%0d: got disp=%h idx=%0d act=%b expected %h/%0d/1",
                 i, disp_time, lap_idx, recall_active, exp_disp[i], i);
      end
    end
    step(0, 0, 1, 0, 16'h0999);
    checks++;
    if (recall_active !== 1'b0 || lap_idx !== 2'd0) begin
      errors++; $display("[TB] FAIL recall_exit: got act=%b idx=%0d expected 0/0", recall_active, lap_idx);
    end
    step(0, 0, 0, 0, 16'h1000);
    checks++;
    if (disp_time !== 16'h1000) begin
      errors++; $display("[TB] FAIL live_after_recall: got %h expected 1000", disp_time);
    end
  endtask

  task automatic test_overwrite();
    step(0, 1, 0, 0, 16'h0000);
    for (int i = 1; i <= 6; i++) step(1, 0, 0, 0, 16'(i));
    checks++;
    if (lap_count !== 3'd4) begin
      errors++; $display("[TB] FAIL overwrite_count: got %0d expected 4", lap_count);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 16'h0000);
      checks++;
      if (disp_time !== 16'(6 - i)) begin
        errors++; $display("[TB] FAIL overwrite_recall%0d: got %h expected %h", i, disp_time, 16'(6 - i));
      end
    end
    step(0, 0, 1, 0, 16'h0000);
  endtask

  task automatic test_timeout();
    step(0, 0, 1, 0, 16'h0000);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 16'h0000);
    checks++;
    if (recall_active !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_early: got act=%b expected 1 after 4 ticks", recall_active);
    end
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if (recall_active !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_fire: got act=%b expected 0 after 5 ticks", recall_active);
    end
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 0, 1, 1, 16'h0000);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 16'h0000);
    checks++;
    if (recall_active !== 1'b1 || lap_idx !== 2'd1) begin
      errors++; $display("[TB] FAIL timeout_restart: got act=%b idx=%0d expected 1/1", recall_active, lap_idx);
    end
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if (recall_active !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_restart_fire: got act=%b expected 0", recall_active);
    end
  endtask

  task automatic test_lap_during_show();
    step(0, 1, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0011);
    step(1, 0, 0, 0, 16'h0022);
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 1, 0, 16'h0789);
    checks++;
    if (recall_active !== 1'b0 || lap_count !== 3'd3 || disp_time !== 16'h0789) begin
      errors++; $display("[TB] FAIL lap_recall_same: got act=%b cnt=%0d disp=%h expected 0/3/0789",
                         recall_active, lap_count, disp_time);
    end
    step(0, 0, 1, 0, 16'h0000);
    checks++;
    if (disp_time !== 16'h0789 || lap_idx !== 2'd0) begin
      errors++; $display("[TB] FAIL new_lap_newest: got disp=%h idx=%0d expected 0789/0", disp_time, lap_idx);
    end
    step(1, 1, 0, 0, 16'h0555);
    checks++;
    if (lap_count !== 3'd0 || recall_active !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_beats_lap: got cnt=%0d act=%b expected 0/0", lap_count, recall_active);
    end
    step(0, 0, 1, 0, 16'h0000);
    checks++;
    if (recall_active !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_nothing_stored: got act=%b expected 0", recall_active);
    end
  endtask

`ifdef LAP_RECALL_BLINK_EN
  task automatic test_blink();
    bit exp_seq [3];
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0;
    step(1, 0, 0, 0, 16'h0042);
    step(0, 0, 1, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (disp_blank !== exp_seq[i]) begin
        errors++; $display("[TB] FAIL blink_seq%0d: got %b expected %b", i, disp_blank, exp_seq[i]);
      end
      step(0, 0, 0, 1, 16'h0000);
    end
    step(0, 0, 1, 0, 16'h0000);
    checks++;
    if (disp_blank !== 1'b0 || recall_active !== 1'b0) begin
      errors++; $display("[TB] FAIL blink_live: got blank=%b act=%b expected 0/0", disp_blank, recall_active);
    end
  endtask
`endif

  task automatic test_reset_mid_show();
    step(1, 0, 0, 0, 16'h0077);
    step(0, 0, 1, 1, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if (recall_active !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_show_setup: got act=%b expected 1", recall_active);
    end
    lap = 0; clr = 0; recall = 0; tick = 0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (disp_time !== 16'h0000 || recall_active !== 1'b0 || lap_idx !== 2'd0 || lap_count !== 3'd0) begin
      errors++; $display("[TB] FAIL async_reset: got disp=%h act=%b idx=%0d cnt=%0d expected all zero",
                         disp_time, recall_active, lap_idx, lap_count);
    end
`ifdef LAP_RECALL_BLINK_EN
    checks++;
    if (disp_blank !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_blank: got %b expected 0", disp_blank);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    bit l, c, r, t;
    logic [15:0] lt;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 2) == 0);
      t  = ($urandom_range(0, 2) == 0);
      lt = 16'($urandom);
      step(l, c, r, t, lt);
      checks++;
      if (disp_time !== model_disp()) begin
        errors++; $display("[TB] FAIL rand_disp cycle %0d: got %h expected %h", i, disp_time, model_disp());
      end
      checks++;
      if (recall_active !== m_show) begin
        errors++; $display("[TB] FAIL rand_active cycle %0d: got %b expected %b", i, recall_active, m_show);
      end
      checks++;
      if (lap_idx !== 2'(m_age)) begin
        errors++; $display("[TB] FAIL rand_idx cycle %0d: got %0d expected %0d", i, lap_idx, m_age);
      end
      checks++;
      if (lap_count !== 3'(m_laps.size())) begin
        errors++; $display("[TB] FAIL rand_count cycle %0d: got %0d expected %0d", i, lap_count, m_laps.size());
      end
`ifdef LAP_RECALL_BLINK_EN
      checks++;
      if (disp_blank !== m_blank) begin
        errors++; $display("[TB] FAIL rand_blank cycle %0d: got %b expected %b", i, disp_blank, m_blank);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_live_idle();
    test_recall_seq();
    test_overwrite();
    test_timeout();
    test_lap_during_show();
`ifdef LAP_RECALL_BLINK_EN
    test_blink();
`endif
    test_reset_mid_show();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
